// File: rtl/vga_pkg.sv
// Shared VGA types: screen bounds, coordinate types, pixel bundle.
// Exports coord_x_t, coord_y_t, pixel_t and the on_screen() helper.
package vga_pkg;

  typedef logic [9:0] coord_x_t;
  typedef logic [8:0] coord_y_t;

  localparam coord_x_t SCREEN_W = 10'd640;
  localparam coord_y_t SCREEN_H = 9'd480;

  localparam int COLOR_W_MAX = 8;

  typedef struct packed {
    coord_x_t                 x;
    coord_y_t                 y;
    logic [COLOR_W_MAX-1:0]   color;
  } pixel_t;

  function automatic logic on_screen(
    input coord_x_t x,
    input coord_y_t y
  );
    return (x < SCREEN_W) && (y < SCREEN_H);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Ports: req (request vector), ptr (scan start), found, idx (winner).
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  int         j;
  logic [IW-1:0] jj;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin burst arbiter for the frame-buffer write port.
// Ports: req/req_x/req_y/req_color in, grant out, fb_* write port, stats.
import vga_pkg::*;

module fb_write_arbiter #(
  parameter int NREQ    = 4,
  parameter int BURST   = 16,
  parameter int COLOR_W = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NREQ-1:0]                req,
  input  coord_x_t [NREQ-1:0]            req_x,
  input  coord_y_t [NREQ-1:0]            req_y,
  input  logic [NREQ-1:0][COLOR_W-1:0]   req_color,
  output logic [NREQ-1:0]                grant,
  input  logic                           frame_start,
  output logic                           fb_wr_en,
  output coord_x_t                       fb_x,
  output coord_y_t                       fb_y,
  output logic [COLOR_W-1:0]             fb_color,
  output logic [15:0]                    drop_count,
  output logic [19:0]                    last_frame_writes
);

  localparam int            IW      = $clog2(NREQ);
  localparam logic [7:0]    BURST_C = 8'(BURST);
  localparam logic [IW-1:0] LAST    = IW'(NREQ - 1);

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  logic                owner_valid_q, owner_valid_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [7:0]          burst_cnt_q, burst_cnt_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                fb_wr_en_q, fb_wr_en_d;
  coord_x_t            fb_x_q, fb_x_d;
  coord_y_t            fb_y_q, fb_y_d;
  logic [COLOR_W-1:0]  fb_color_q, fb_color_d;
  logic [15:0]         drop_q, drop_d;
  logic [19:0]         frame_writes_q, frame_writes_d;
  logic [19:0]         last_fw_q, last_fw_d;

  logic                cont;
  logic                exhausted;
  logic [IW-1:0]       scan_ptr;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;
  logic                vis;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (scan_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    cont      = owner_valid_q && req[owner_q]
                && (burst_cnt_q < BURST_C);
    exhausted = owner_valid_q && (burst_cnt_q >= BURST_C);
    // An exhausted owner yields: scan starts just past it.
    scan_ptr  = exhausted ? inc(owner_q) : rr_ptr_q;
    gnt_idx   = cont ? owner_q : pick_idx;
    gnt_any   = !reset && (cont || pick_found);
    grant     = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    vis       = on_screen(req_x[gnt_idx], req_y[gnt_idx]);

    owner_valid_d = owner_valid_q;
    owner_d       = owner_q;
    burst_cnt_d   = burst_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    if (cont) begin
      burst_cnt_d = burst_cnt_q + 8'd1;
    end else if (pick_found) begin
      owner_valid_d = 1'b1;
      owner_d       = pick_idx;
      burst_cnt_d   = 8'd1;
      rr_ptr_d      = inc(pick_idx);
    end else begin
      owner_valid_d = 1'b0;
    end

    fb_wr_en_d = gnt_any && vis;
    fb_x_d     = fb_x_q;
    fb_y_d     = fb_y_q;
    fb_color_d = fb_color_q;
    drop_d     = drop_q;
    if (gnt_any) begin
      fb_x_d     = req_x[gnt_idx];
      fb_y_d     = req_y[gnt_idx];
      fb_color_d = req_color[gnt_idx];
      if (!vis && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    // The strobe visible during frame_start opens the new frame.
    last_fw_d      = last_fw_q;
    frame_writes_d = frame_writes_q;
    if (frame_start) begin
      last_fw_d      = frame_writes_q;
      frame_writes_d = {19'd0, fb_wr_en_q};
    end else if (fb_wr_en_q && frame_writes_q != 20'hFFFFF) begin
      frame_writes_d = frame_writes_q + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_valid_q  <= 1'b0;
      owner_q        <= '0;
      burst_cnt_q    <= '0;
      rr_ptr_q       <= '0;
      fb_wr_en_q     <= 1'b0;
      fb_x_q         <= '0;
      fb_y_q         <= '0;
      fb_color_q     <= '0;
      drop_q         <= '0;
      frame_writes_q <= '0;
      last_fw_q      <= '0;
    end else begin
      owner_valid_q  <= owner_valid_d;
      owner_q        <= owner_d;
      burst_cnt_q    <= burst_cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      fb_wr_en_q     <= fb_wr_en_d;
      fb_x_q         <= fb_x_d;
      fb_y_q         <= fb_y_d;
      fb_color_q     <= fb_color_d;
      drop_q         <= drop_d;
      frame_writes_q <= frame_writes_d;
      last_fw_q      <= last_fw_d;
    end
  end

  assign fb_wr_en          = fb_wr_en_q;
  assign fb_x              = fb_x_q;
  assign fb_y              = fb_y_q;
  assign fb_color          = fb_color_q;
  assign drop_count        = drop_q;
  assign last_frame_writes = last_fw_q;

endmodule
